// File: rtl/up_down_counter_multi_channel.sv
// NUM_CH independent up/down counters sharing one clock. Each channel counts modulo
// MAX_VAL+1 (or saturates), with a registered terminal-count pulse and a sticky overflow flag.
module up_down_counter_multi_channel #(
  parameter int WIDTH     = 5,
  parameter int NUM_CH    = 2,
  parameter int MAX_VAL   = 2**WIDTH - 1,
  parameter int SATURATE  = 0,
  parameter int RESET_VAL = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       dir,
  input  logic [NUM_CH-1:0]       clr,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] load_val,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       tc,
  output logic [NUM_CH-1:0]       ovf
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam bit               SAT   = (SATURATE != 0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [WIDTH-1:0] cnt_q, cnt_d;
      logic [WIDTH-1:0] ld_val;
      logic             tc_q, tc_d;
      logic             ovf_q, ovf_d;

      assign ld_val = load_val[gi*WIDTH +: WIDTH];

      // Bounds are checked before stepping, so the +1/-1 never wraps at 2**WIDTH.
      always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q;
        if (clr[gi]) begin
          cnt_d = RST_W;
          ovf_d = 1'b0;
        end else if (load[gi]) begin
          cnt_d = (ld_val > MAX_W) ? MAX_W : ld_val;
        end else if (en[gi]) begin
          if (dir[gi]) begin
            if (cnt_q >= MAX_W) begin
              cnt_d = SAT ? MAX_W : '0;
              tc_d  = 1'b1;
              ovf_d = 1'b1;
            end else begin
              cnt_d = cnt_q + ONE_W;
            end
          end else begin
            if (cnt_q == '0) begin
              cnt_d = SAT ? '0 : MAX_W;
              tc_d  = 1'b1;
              ovf_d = 1'b1;
            end else begin
              cnt_d = cnt_q - ONE_W;
            end
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_q <= RST_W;
          tc_q  <= 1'b0;
          ovf_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          tc_q  <= tc_d;
          ovf_q <= ovf_d;
        end
      end

      assign count[gi*WIDTH +: WIDTH] = cnt_q;
      assign tc[gi]                   = tc_q;
      assign ovf[gi]                  = ovf_q;
    end
  endgenerate

endmodule

// File: tb/tb_up_down_counter_multi_channel.sv
// Directed bench for up_down_counter_multi_channel: default wrap instance plus
// MAX_VAL=9 wrap and saturate instances, all sharing clock and reset.
module tb_up_down_counter_multi_channel;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [1:0] en_a, dir_a, clr_a, load_a, tc_a, ovf_a;
  logic [9:0] lv_a, cnt_a;
  logic [1:0] en_b, dir_b, clr_b, load_b, tc_b, ovf_b;
  logic [9:0] lv_b, cnt_b;
  logic [1:0] en_c, dir_c, clr_c, load_c, tc_c, ovf_c;
  logic [9:0] lv_c, cnt_c;

  int total = 0;
  int bad   = 0;

  up_down_counter_multi_channel #(.WIDTH(5), .NUM_CH(2)) u_a (
    .clk(clk), .reset(reset), .en(en_a), .dir(dir_a), .clr(clr_a), .load(load_a),
    .load_val(lv_a), .count(cnt_a), .tc(tc_a), .ovf(ovf_a));

  up_down_counter_multi_channel #(.WIDTH(5), .NUM_CH(2), .MAX_VAL(9), .SATURATE(0)) u_b (
    .clk(clk), .reset(reset), .en(en_b), .dir(dir_b), .clr(clr_b), .load(load_b),
    .load_val(lv_b), .count(cnt_b), .tc(tc_b), .ovf(ovf_b));

  up_down_counter_multi_channel #(.WIDTH(5), .NUM_CH(2), .MAX_VAL(9), .SATURATE(1)) u_c (
    .clk(clk), .reset(reset), .en(en_c), .dir(dir_c), .clr(clr_c), .load(load_c),
    .load_val(lv_c), .count(cnt_c), .tc(tc_c), .ovf(ovf_c));

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    en_a = '0; dir_a = '0; clr_a = '0; load_a = '0; lv_a = '0;
    en_b = '0; dir_b = '0; clr_b = '0; load_b = '0; lv_b = '0;
    en_c = '0; dir_c = '0; clr_c = '0; load_c = '0; lv_c = '0;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst cnt_a c%0d", i), int'(cnt_a), 0);
      chk($sformatf("rst tc_a c%0d", i), int'(tc_a), 0);
      chk($sformatf("rst ovf_a c%0d", i), int'(ovf_a), 0);
    end

    // ch0 up, ch1 down, 40 edges
    reset = 1'b1;
    en_a  = 2'b11;
    dir_a = 2'b01;
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk($sformatf("t1 cnt0 k=%0d", k), int'(cnt_a[4:0]), k % 32);
      chk($sformatf("t1 tc0 k=%0d", k), int'(tc_a[0]), (k == 32) ? 1 : 0);
      chk($sformatf("t1 ovf0 k=%0d", k), int'(ovf_a[0]), (k >= 32) ? 1 : 0);
      chk($sformatf("t2 cnt1 k=%0d", k), int'(cnt_a[9:5]), (32 - (k % 32)) % 32);
      chk($sformatf("t2 tc1 k=%0d", k), int'(tc_a[1]), (k == 1 || k == 33) ? 1 : 0);
      chk($sformatf("t2 ovf1 k=%0d", k), int'(ovf_a[1]), 1);
    end

    // Load wins over enable
    en_a = 2'b01; dir_a = 2'b01; load_a = 2'b01; lv_a = {5'd0, 5'd17};
    tick();
    chk("t3 load cnt0", int'(cnt_a[4:0]), 17);
    chk("t3 load tc0", int'(tc_a[0]), 0);
    chk("t3 load ovf0", int'(ovf_a[0]), 1);
    chk("t3 idle cnt1", int'(cnt_a[9:5]), 24);
    chk("t3 idle tc1", int'(tc_a[1]), 0);
    load_a = 2'b00;
    tick();
    chk("t3 step cnt0", int'(cnt_a[4:0]), 18);

    // Clear beats load while counting
    clr_a = 2'b01; load_a = 2'b01;
    tick();
    chk("t4 clr cnt0", int'(cnt_a[4:0]), 0);
    chk("t4 clr ovf0", int'(ovf_a[0]), 0);
    chk("t4 clr tc0", int'(tc_a[0]), 0);
    chk("t4 clr cnt1", int'(cnt_a[9:5]), 24);
    chk("t4 clr ovf1", int'(ovf_a[1]), 1);
    clr_a = 2'b00; load_a = 2'b00;
    tick();
    chk("t4 post clr1", int'(cnt_a[4:0]), 1);
    tick();
    chk("t4 post clr2", int'(cnt_a[4:0]), 2);

    // Asynchronous reset between edges
    #2 reset = 1'b0;
    #1;
    chk("t4 async cnt", int'(cnt_a), 0);
    chk("t4 async tc", int'(tc_a), 0);
    chk("t4 async ovf", int'(ovf_a), 0);
    tick();
    reset = 1'b1;
    en_a  = 2'b00;

    // MAX_VAL=9: wrap instance up/down, saturate instance up and down-at-zero
    en_b = 2'b11; dir_b = 2'b01;
    en_c = 2'b11; dir_c = 2'b01;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("t5 b cnt0 k=%0d", k), int'(cnt_b[4:0]), k % 10);
      chk($sformatf("t5 b tc0 k=%0d", k), int'(tc_b[0]), (k == 10) ? 1 : 0);
      chk($sformatf("t5 b cnt1 k=%0d", k), int'(cnt_b[9:5]), (10 - (k % 10)) % 10);
      chk($sformatf("t5 b tc1 k=%0d", k), int'(tc_b[1]), ((k % 10) == 1) ? 1 : 0);
      chk($sformatf("t6 c cnt0 k=%0d", k), int'(cnt_c[4:0]), (k < 9) ? k : 9);
      chk($sformatf("t6 c tc0 k=%0d", k), int'(tc_c[0]), (k >= 10) ? 1 : 0);
      chk($sformatf("t6 c ovf0 k=%0d", k), int'(ovf_c[0]), (k >= 10) ? 1 : 0);
      chk($sformatf("t6 c cnt1 k=%0d", k), int'(cnt_c[9:5]), 0);
      chk($sformatf("t6 c tc1 k=%0d", k), int'(tc_c[1]), 1);
    end

    // Clamped load, direction change at saturated bound
    en_b = 2'b00; load_b = 2'b11; lv_b = {5'd5, 5'd25};
    en_c = 2'b01; dir_c = 2'b00;
    tick();
    chk("t5 clamp cnt0", int'(cnt_b[4:0]), 9);
    chk("t5 plain cnt1", int'(cnt_b[9:5]), 5);
    chk("t5 load tc", int'(tc_b), 0);
    chk("t5 ovf kept", int'(ovf_b), 3);
    chk("t6 down cnt0", int'(cnt_c[4:0]), 8);
    chk("t6 down tc0", int'(tc_c[0]), 0);
    chk("t6 ovf0 kept", int'(ovf_c[0]), 1);
    chk("t6 idle cnt1", int'(cnt_c[9:5]), 0);
    chk("t6 idle tc1", int'(tc_c[1]), 0);
    chk("t6 ovf1 kept", int'(ovf_c[1]), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
